rtc_bus_sequencer: RTL

- Downstream of the general RTC control state machine; converts its RW direction into one complete RTC bus transaction per start request.
- Drives the RTC's multiplexed address/data interface: A/D select, CS_n, RD_n, WR_n, and a tri-state AD bus split into out/oe/in.
- One transaction is an address-write phase followed by a data read or data write phase.
- Returns read data with a valid pulse and signals completion.

---
 rtl/rtc_bus_pkg.sv | 43 ++++
 rtl/rtc_phase_timer.sv | 32 +++
 rtl/rtc_bus_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus sequencer.
// Holds the sequencer state encoding, the default phase timings, the RTC
// register map and a small helper used to size the phase counter.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_SETUP,
        ADDR_STROBE,
        ADDR_HOLD,
        GAP,
        DATA_STROBE,
        DATA_HOLD,
        DONE
    } bus_state_t;

    // Default phase lengths, in clock cycles
    localparam int DEF_T_SETUP  = 2;
    localparam int DEF_T_STROBE = 8;
    localparam int DEF_T_HOLD   = 2;
    localparam int DEF_T_GAP    = 4;

    // RTC register addresses
    localparam logic [7:0] RTC_SECONDS = 8'h20;
    localparam logic [7:0] RTC_MINUTES = 8'h21;
    localparam logic [7:0] RTC_HOURS   = 8'h22;
    localparam logic [7:0] RTC_DATE    = 8'h23;
    localparam logic [7:0] RTC_MONTH   = 8'h24;
    localparam logic [7:0] RTC_YEAR    = 8'h25;
    localparam logic [7:0] RTC_TIMER   = 8'h26;
    localparam logic [7:0] RTC_COMMAND = 8'h27;

    // Largest of the four phase lengths; sizes the shared phase counter
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter with a zero flag, shared by every bus phase.
// Ports:
//   clk, Reset  - clock and asynchronous active-high reset
//   load        - load load_value this edge (takes priority over counting)
//   load_value  - phase length minus one
//   zero        - high while the count is 0 (last cycle of the phase)
module rtc_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count;

    // Count down to zero and park there until the next load
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// RTC bus sequencer: turns one go request into a full multiplexed RTC bus
// transaction (address write phase, then data read or data write phase).
// Ports:
//   clk, Reset         - clock and asynchronous active-high reset
//   go, RW, addr, wdata - request; sampled only while idle
//   ad_in              - AD bus value from the pad
//   ad_out, ad_oe      - AD bus drive value and output enable
//   AD_sel             - 0 address cycle, 1 data cycle
//   CS_n, RD_n, WR_n   - active-low chip select and strobes
//   busy               - transaction in progress
//   done               - one-cycle end-of-transaction pulse
//   rdata, rdata_valid - last read data and its one-cycle valid pulse
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP  = DEF_T_SETUP,
    parameter int T_STROBE = DEF_T_STROBE,
    parameter int T_HOLD   = DEF_T_HOLD,
    parameter int T_GAP    = DEF_T_GAP
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       go,
    input  logic       RW,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       AD_sel,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       rdata_valid
);

    localparam int CW = $clog2(max4(T_SETUP, T_STROBE, T_HOLD, T_GAP)) + 1;

    localparam logic [CW-1:0] LD_SETUP  = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_STROBE = CW'(T_STROBE - 1);
    localparam logic [CW-1:0] LD_HOLD   = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_GAP    = CW'(T_GAP - 1);

    bus_state_t    state;
    bus_state_t    next_state;
    logic          timer_load;
    logic [CW-1:0] timer_value;
    logic          timer_zero;
    logic          rw_q;
    logic [7:0]    addr_q;
    logic [7:0]    wdata_q;
    logic          accept;
    logic          sel_rw;
    logic [7:0]    sel_addr;
    logic [7:0]    sel_wdata;

    rtc_phase_timer #(.W(CW)) u_timer (
        .clk        (clk),
        .Reset      (Reset),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // Next-state and timer-load decode. Each phase ends when the shared
    // counter hits zero, at which point the next phase length is loaded.
    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            IDLE: begin
                if (go) begin
                    next_state  = ADDR_SETUP;
                    timer_load  = 1'b1;
                    timer_value = LD_SETUP;
                end
            end
            ADDR_SETUP: begin
                if (timer_zero) begin
                    next_state  = ADDR_STROBE;
                    timer_load  = 1'b1;
                    timer_value = LD_STROBE;
                end
            end
            ADDR_STROBE: begin
                if (timer_zero) begin
                    next_state  = ADDR_HOLD;
                    timer_load  = 1'b1;
                    timer_value = LD_HOLD;
                end
            end
            ADDR_HOLD: begin
                if (timer_zero) begin
                    next_state  = GAP;
                    timer_load  = 1'b1;
                    timer_value = LD_GAP;
                end
            end
            GAP: begin
                if (timer_zero) begin
                    next_state  = DATA_STROBE;
                    timer_load  = 1'b1;
                    timer_value = LD_STROBE;
                end
            end
            DATA_STROBE: begin
                if (timer_zero) begin
                    next_state  = DATA_HOLD;
                    timer_load  = 1'b1;
                    timer_value = LD_HOLD;
                end
            end
            DATA_HOLD: begin
                if (timer_zero) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // On the accept edge the request registers are not yet loaded, so the
    // outputs for the first phase are decoded straight from the inputs.
    assign accept    = (state == IDLE) && go;
    assign sel_rw    = accept ? RW    : rw_q;
    assign sel_addr  = accept ? addr  : addr_q;
    assign sel_wdata = accept ? wdata : wdata_q;

    // State register with all bus pins decoded from the next state, so every
    // pin is a flop and only changes on a phase boundary.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            rw_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            rdata       <= 8'h00;
            ad_out      <= 8'h00;
            ad_oe       <= 1'b0;
            AD_sel      <= 1'b1;
            CS_n        <= 1'b1;
            RD_n        <= 1'b1;
            WR_n        <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            rdata_valid <= 1'b0;
        end else begin
            state <= next_state;

            if (accept) begin
                rw_q    <= RW;
                addr_q  <= addr;
                wdata_q <= wdata;
            end

            // The read sample point is the edge that closes the last strobe cycle
            if (state == DATA_STROBE && timer_zero && rw_q) begin
                rdata <= ad_in;
            end

            ad_out      <= 8'h00;
            ad_oe       <= 1'b0;
            AD_sel      <= 1'b1;
            CS_n        <= 1'b1;
            RD_n        <= 1'b1;
            WR_n        <= 1'b1;
            busy        <= (next_state != IDLE) && (next_state != DONE);
            done        <= (next_state == DONE);
            rdata_valid <= (next_state == DONE) && rw_q;

            case (next_state)
                ADDR_SETUP, ADDR_HOLD: begin
                    AD_sel <= 1'b0;
                    ad_oe  <= 1'b1;
                    ad_out <= sel_addr;
                end
                ADDR_STROBE: begin
                    AD_sel <= 1'b0;
                    ad_oe  <= 1'b1;
                    ad_out <= sel_addr;
                    CS_n   <= 1'b0;
                    WR_n   <= 1'b0;
                end
                DATA_STROBE: begin
                    CS_n <= 1'b0;
                    if (sel_rw) begin
                        RD_n <= 1'b0;
                    end else begin
                        WR_n   <= 1'b0;
                        ad_oe  <= 1'b1;
                        ad_out <= sel_wdata;
                    end
                end
                DATA_HOLD: begin
                    if (!sel_rw) begin
                        ad_oe  <= 1'b1;
                        ad_out <= sel_wdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
